// File: rtl/out_sig_reducer.sv
// out_sig_reducer: folds NUM_CH kernel streams into a narrow XOR digest
// and keeps a per-run signature, beat count and start/done/drain FSM.
module out_sig_reducer #(
  parameter int  NUM_CH     = 2,
  parameter int  DIN_WIDTH  = 32,
  parameter int  MID_WIDTH  = 8,
  parameter int  DOUT_WIDTH = 4,
  parameter int  SIG_WIDTH  = 16,
  parameter int  CNT_WIDTH  = 16,
  localparam int PIPE_LAT   = 3
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        ap_start,
  input  logic                        ap_done,
  input  logic [NUM_CH*DIN_WIDTH-1:0] ch_din,
  input  logic [NUM_CH-1:0]           ch_write,
  output logic [DOUT_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic [SIG_WIDTH-1:0]        signature,
  output logic [CNT_WIDTH-1:0]        beat_count,
  output logic                        sig_valid,
  output logic                        busy
);

  localparam int NSL1 = DIN_WIDTH / MID_WIDTH;
  localparam int NSL2 = MID_WIDTH / DOUT_WIDTH;
  localparam int DCW  = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  logic [NUM_CH-1:0][MID_WIDTH-1:0] w_fold1;
  logic [NUM_CH-1:0][MID_WIDTH-1:0] r_fold1;
  logic [NUM_CH-1:0]                r_v1;
  logic [MID_WIDTH-1:0]             w_fold2;
  logic [MID_WIDTH-1:0]             r_fold2;
  logic                             r_v2;
  logic [DOUT_WIDTH-1:0]            w_dout;
  logic [DOUT_WIDTH-1:0]            r_data_out;
  logic                             r_data_valid;

  state_t                           r_state;
  state_t                           w_next;
  logic [DCW-1:0]                   r_drain_cnt;
  logic [DCW-1:0]                   w_drain_nxt;
  logic                             w_clear;
  logic                             w_acc;
  logic [SIG_WIDTH-1:0]             r_sig;
  logic [SIG_WIDTH-1:0]             w_dext;
  logic [CNT_WIDTH-1:0]             r_cnt;
  logic                             r_sig_valid;
  logic                             r_busy;

  // Per-channel fold of the wide word down to MID_WIDTH.
  always_comb begin
    w_fold1 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int s = 0; s < NSL1; s++) begin
        w_fold1[k] = w_fold1[k]
          ^ ch_din[k*DIN_WIDTH + s*MID_WIDTH +: MID_WIDTH];
      end
    end
  end

  // Combine only the channels that were written this beat.
  always_comb begin
    w_fold2 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_v1[k]) begin
        w_fold2 = w_fold2 ^ r_fold1[k];
      end
    end
  end

  // Final fold down to the pin width.
  always_comb begin
    w_dout = '0;
    for (int s = 0; s < NSL2; s++) begin
      w_dout = w_dout ^ r_fold2[s*DOUT_WIDTH +: DOUT_WIDTH];
    end
  end

  // Three-stage fold pipeline; data_out is forced to 0 on idle beats.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_fold1      <= '0;
      r_v1         <= '0;
      r_fold2      <= '0;
      r_v2         <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_fold1      <= w_fold1;
      r_v1         <= ch_write;
      r_fold2      <= w_fold2;
      r_v2         <= |r_v1;
      r_data_out   <= r_v2 ? w_dout : '0;
      r_data_valid <= r_v2;
    end
  end

  // FSM next state; DRAIN covers the beats still inside the pipeline.
  always_comb begin
    w_next      = r_state;
    w_drain_nxt = r_drain_cnt;
    w_clear     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_clear = 1'b1;
          w_next  = S_RUN;
        end
      end
      S_RUN: begin
        if (ap_done) begin
          w_drain_nxt = DCW'(PIPE_LAT);
          w_next      = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_drain_nxt = r_drain_cnt - DCW'(1);
        if (w_drain_nxt == '0) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (ap_start) begin
          w_clear = 1'b1;
          w_next  = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state plus registered status flags derived from the next state.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_sig_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_drain_cnt <= w_drain_nxt;
      r_busy      <= (w_next == S_RUN) || (w_next == S_DRAIN);
      r_sig_valid <= (w_next == S_DONE);
    end
  end

  // Accumulate only while a run is live and a beat is on the pins.
  always_comb begin
    w_acc  = ((r_state == S_RUN) || (r_state == S_DRAIN))
             && r_data_valid;
    w_dext = '0;
    w_dext[DOUT_WIDTH-1:0] = r_data_out;
  end

  // Signature and saturating beat counter; a clear beats a same-cycle beat.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_sig <= '0;
      r_cnt <= '0;
    end else if (w_clear) begin
      r_sig <= '0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_sig <= {r_sig[SIG_WIDTH-2:0], r_sig[SIG_WIDTH-1]} ^ w_dext;
      if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign signature  = r_sig;
  assign beat_count = r_cnt;
  assign sig_valid  = r_sig_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_out_sig_reducer.sv
// tb_out_sig_reducer: random plus directed stimulus against a
// cycle-level reference model of the digest and run signature.
module tb_out_sig_reducer;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int OW  = 4;
  localparam int SW  = 16;

  logic            ap_clk = 1'b0;
  logic            ap_rst = 1'b1;
  logic            ap_start = 1'b0;
  logic            ap_done = 1'b0;
  logic [NCH*DW-1:0] ch_din = '0;
  logic [NCH-1:0]  ch_write = '0;

  logic [OW-1:0]   data_out, data_out4;
  logic            data_valid, data_valid4;
  logic [SW-1:0]   signature, signature4;
  logic [15:0]     beat_count;
  logic [3:0]      beat_count4;
  logic            sig_valid, sig_valid4;
  logic            busy, busy4;

  always #5 ap_clk = ~ap_clk;

  out_sig_reducer u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .ap_start(ap_start), .ap_done(ap_done),
    .ch_din(ch_din), .ch_write(ch_write),
    .data_out(data_out), .data_valid(data_valid),
    .signature(signature), .beat_count(beat_count),
    .sig_valid(sig_valid), .busy(busy)
  );

  out_sig_reducer #(.CNT_WIDTH(4)) u_dut4 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .ap_start(ap_start), .ap_done(ap_done),
    .ch_din(ch_din), .ch_write(ch_write),
    .data_out(data_out4), .data_valid(data_valid4),
    .signature(signature4), .beat_count(beat_count4),
    .sig_valid(sig_valid4), .busy(busy4)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       v;
    logic [3:0] d;
  } beat_t;

  beat_t       m_q[$];
  beat_t       m_out;
  bit          m_active, m_dseen, m_final;
  int          m_after;
  logic [15:0] m_sig;
  int          m_cnt;

  // Digest of one input beat: XOR the written words, then all nibbles.
  function automatic beat_t ref_beat(input logic [NCH-1:0] wr,
                                     input logic [NCH*DW-1:0] din);
    logic [DW-1:0] w;
    logic [3:0]    d;
    w = '0;
    d = '0;
    for (int k = 0; k < NCH; k++)
      if (wr[k]) w = w ^ din[k*DW +: DW];
    for (int i = 0; i < DW/4; i++) d = d ^ w[i*4 +: 4];
    return '{v: |wr, d: (|wr) ? d : 4'h0};
  endfunction

  task automatic model_reset();
    m_q = {};
    m_q.push_back('0);
    m_q.push_back('0);
    m_out    = '0;
    m_active = 0;
    m_dseen  = 0;
    m_final  = 0;
    m_after  = 0;
    m_sig    = '0;
    m_cnt    = 0;
  endtask

  task automatic model_edge(input logic [NCH-1:0] wr,
                            input logic [NCH*DW-1:0] din,
                            input logic st, input logic dn);
    beat_t prev;
    bit    acc;
    prev = m_out;
    acc  = m_active && prev.v;
    m_q.push_back(ref_beat(wr, din));
    m_out = m_q.pop_front();
    if (!m_active) begin
      if (st) begin
        m_sig    = '0;
        m_cnt    = 0;
        m_active = 1;
        m_dseen  = 0;
        m_final  = 0;
      end
    end else begin
      if (acc) begin
        m_sig = 16'((m_sig << 1) | (m_sig >> 15)) ^ {12'h0, prev.d};
        m_cnt++;
      end
      if (m_dseen) begin
        m_after++;
        if (m_after == 3) begin
          m_active = 0;
          m_final  = 1;
        end
      end else if (dn) begin
        m_dseen = 1;
        m_after = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    int c16, c4;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c4  = (m_cnt > 15) ? 15 : m_cnt;
    chk({tag, ".dv"},   32'(data_valid),  32'(m_out.v));
    chk({tag, ".dout"}, 32'(data_out),    32'(m_out.d));
    chk({tag, ".sig"},  32'(signature),   32'(m_sig));
    chk({tag, ".cnt"},  32'(beat_count),  32'(c16));
    chk({tag, ".sv"},   32'(sig_valid),   32'(m_final));
    chk({tag, ".busy"}, 32'(busy),        32'(m_active));
    chk({tag, ".sig4"}, 32'(signature4),  32'(m_sig));
    chk({tag, ".cnt4"}, 32'(beat_count4), 32'(c4));
    chk({tag, ".dv4"},  32'(data_valid4), 32'(m_out.v));
  endtask

  task automatic tick(input string tag, input logic [NCH-1:0] wr,
                      input logic [NCH*DW-1:0] din,
                      input logic st, input logic dn);
    ch_write = wr;
    ch_din   = din;
    ap_start = st;
    ap_done  = dn;
    @(posedge ap_clk);
    #1;
    model_edge(wr, din, st, dn);
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    ch_write = '0;
    ap_start = 1'b0;
    ap_done  = 1'b0;
    ap_rst   = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    compare_all({tag, ".hold"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  localparam logic [NCH*DW-1:0] W_A  = {32'h0, 32'h12345678};
  localparam logic [NCH*DW-1:0] W_AB = {32'h000000A5, 32'h12345678};

  initial begin
    model_reset();
    @(posedge ap_clk);
    #1;
    do_reset("rst0");

    tick("tp1", 2'b01, W_A, 1'b0, 1'b0);
    idle("tp1", 2);
    chk("tp1_valid", 32'(data_valid), 32'h1);
    chk("tp1_dout", 32'(data_out), 32'h8);
    idle("tp1", 1);
    chk("tp1_valid_off", 32'(data_valid), 32'h0);
    chk("tp1_dout_off", 32'(data_out), 32'h0);

    tick("tp2", 2'b11, W_AB, 1'b0, 1'b0);
    idle("tp2", 2);
    chk("tp2_dout", 32'(data_out), 32'h7);
    idle("tp2", 1);
    chk("tp2_single", 32'(data_valid), 32'h0);

    tick("tp3", '0, '0, 1'b1, 1'b0);
    tick("tp3", 2'b01, W_A, 1'b0, 1'b0);
    tick("tp3", 2'b11, W_AB, 1'b0, 1'b0);
    idle("tp3", 3);
    tick("tp3", '0, '0, 1'b0, 1'b1);
    idle("tp3", 2);
    chk("tp3_sv_early", 32'(sig_valid), 32'h0);
    chk("tp3_busy_early", 32'(busy), 32'h1);
    idle("tp3", 1);
    chk("tp3_sv", 32'(sig_valid), 32'h1);
    chk("tp3_busy", 32'(busy), 32'h0);
    chk("tp3_sig", 32'(signature), 32'h0017);
    chk("tp3_cnt", 32'(beat_count), 32'd2);

    tick("tp4", '0, '0, 1'b1, 1'b0);
    idle("tp4", 1);
    tick("tp4", 2'b01, W_A, 1'b0, 1'b0);
    tick("tp4", '0, '0, 1'b0, 1'b1);
    idle("tp4", 2);
    tick("tp4", 2'b01, W_A, 1'b0, 1'b0);
    idle("tp4", 4);
    tick("tp4", '0, '0, 1'b0, 1'b1);
    chk("tp4_sig", 32'(signature), 32'h0008);
    chk("tp4_cnt", 32'(beat_count), 32'd1);
    chk("tp4_sv", 32'(sig_valid), 32'h1);

    tick("tp5", '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      tick("tp5", 2'b11, {$urandom, $urandom}, 1'b0, 1'b0);
    tick("tp5", '0, '0, 1'b0, 1'b1);
    idle("tp5", 4);
    chk("tp5_cnt4", 32'(beat_count4), 32'd15);
    chk("tp5_cnt16", 32'(beat_count), 32'd20);

    tick("tp6", '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      tick("tp6", 2'b01, {$urandom, $urandom}, 1'b0, 1'b0);
    do_reset("tp6");
    chk("tp6_dv", 32'(data_valid), 32'h0);
    chk("tp6_sig", 32'(signature), 32'h0);
    tick("tp6", '0, '0, 1'b0, 1'b1);
    idle("tp6", 6);
    chk("tp6_sv", 32'(sig_valid), 32'h0);
    chk("tp6_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset("rnd_rst");
      end else begin
        tick("rnd", NCH'($urandom), {$urandom, $urandom},
             ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
